// File: rtl/sobel_pkg.sv
// Shared defaults, counter width and FSM state encoding for the 3-row line buffer.
package sobel_pkg;

  localparam int unsigned DefWidth     = 8;
  localparam int unsigned DefPicWidth  = 320;
  localparam int unsigned DefPicHeight = 240;

  // Wide enough for PIC_WIDTH and PIC_HEIGHT up to 511.
  localparam int unsigned CntW = 9;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StFill0  = 2'd1,
    StFill1  = 2'd2,
    StStream = 2'd3
  } state_e;

endpackage

// File: rtl/line_ram.sv
// Single-clock line memory: the read returns the contents before this cycle's write,
// so a read and a write to the same address in one cycle is read-before-write.
// Contents are deliberately not reset.
module line_ram #(
  parameter int unsigned Width = 8,
  parameter int unsigned Depth = 320,
  parameter int unsigned AddrW = (Depth > 1) ? $clog2(Depth) : 1
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic             re_i,
  input  logic [AddrW-1:0] addr_i,
  input  logic [Width-1:0] wdata_i,
  output logic [Width-1:0] rdata_o
);

  logic [Width-1:0] mem_q [Depth];

  assign rdata_o = re_i ? mem_q[addr_i] : '0;

  // Write on the clock edge; the read above sees the pre-write value.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
  end

endmodule

// File: rtl/line_buf_3row.sv
// Three-row line buffer: emits a column-aligned triple (two rows up, one row up, current)
// one cycle after each accepted pixel once two rows have been buffered.
// Optional feature: define LINE_BUF_EDGE_REPLICATE_EN to also emit triples for the first two
// rows of a frame, replicating the top edge.
module line_buf_3row
  import sobel_pkg::*;
#(
  parameter int unsigned WIDTH      = DefWidth,
  parameter int unsigned PIC_WIDTH  = DefPicWidth,
  parameter int unsigned PIC_HEIGHT = DefPicHeight
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             frame_start,
  input  logic             valid_in,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout1,
  output logic [WIDTH-1:0] dout2,
  output logic [WIDTH-1:0] dout3,
  output logic             valid_out,
  output logic             frame_done
);

  localparam int unsigned AddrW = (PIC_WIDTH > 1) ? $clog2(PIC_WIDTH) : 1;

  state_e            state_q, state_d, cur_state;
  logic [CntW-1:0]   col_q, col_d, cur_col;
  logic [CntW-1:0]   row_q, row_d, cur_row;
  logic              accept, last_col, last_row, emit;
  logic [WIDTH-1:0]  a_rd, b_rd, d1_d, d2_d;
  logic [WIDTH-1:0]  dout1_q, dout2_q, dout3_q;
  logic              valid_q, done_q;

  // Line A holds the previous row, line B the row before it; B takes A's old entry.
  line_ram #(.Width(WIDTH), .Depth(PIC_WIDTH), .AddrW(AddrW)) u_line_a (
    .clk_i   (clk),
    .we_i    (accept),
    .re_i    (accept),
    .addr_i  (cur_col[AddrW-1:0]),
    .wdata_i (din),
    .rdata_o (a_rd)
  );

  line_ram #(.Width(WIDTH), .Depth(PIC_WIDTH), .AddrW(AddrW)) u_line_b (
    .clk_i   (clk),
    .we_i    (accept),
    .re_i    (accept),
    .addr_i  (cur_col[AddrW-1:0]),
    .wdata_i (a_rd),
    .rdata_o (b_rd)
  );

  // Next state and counters; frame_start overrides the current position to row 0, col 0.
  always_comb begin
    cur_state = frame_start ? StFill0 : state_q;
    cur_col   = frame_start ? '0 : col_q;
    cur_row   = frame_start ? '0 : row_q;
    accept    = valid_in && (frame_start || (state_q != StIdle));
    last_col  = (cur_col == CntW'(PIC_WIDTH - 1));
    last_row  = (cur_row == CntW'(PIC_HEIGHT - 1));
    state_d   = cur_state;
    col_d     = cur_col;
    row_d     = cur_row;
    if (accept) begin
      if (last_col) begin
        col_d = '0;
        row_d = last_row ? '0 : cur_row + CntW'(1);
        unique case (cur_state)
          StFill0:  state_d = StFill1;
          StFill1:  state_d = StStream;
          StStream: if (last_row) state_d = StIdle;
          default:  ;
        endcase
      end else begin
        col_d = cur_col + CntW'(1);
      end
    end
  end

  // Decide whether this acceptance produces a triple and select the upper two rows.
  always_comb begin
    emit = 1'b0;
    d1_d = b_rd;
    d2_d = a_rd;
    if (accept) begin
      unique case (cur_state)
        StStream: emit = 1'b1;
`ifdef LINE_BUF_EDGE_REPLICATE_EN
        StFill0: begin
          emit = 1'b1;
          d1_d = din;
          d2_d = din;
        end
        StFill1: begin
          emit = 1'b1;
          d1_d = a_rd;
        end
`endif
        default: ;
      endcase
    end
  end

  // State, counters and registered outputs; outputs hold unless a triple is emitted.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      col_q   <= '0;
      row_q   <= '0;
      dout1_q <= '0;
      dout2_q <= '0;
      dout3_q <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
      valid_q <= emit;
      done_q  <= emit && (cur_state == StStream) && last_col && last_row;
      if (emit) begin
        dout1_q <= d1_d;
        dout2_q <= d2_d;
        dout3_q <= din;
      end
    end
  end

  assign dout1      = dout1_q;
  assign dout2      = dout2_q;
  assign dout3      = dout3_q;
  assign valid_out  = valid_q;
  assign frame_done = done_q;

endmodule

// File: tb/tb_line_buf_3row.sv
// Self-checking bench for line_buf_3row on a 4x4 frame; expected triples are pushed to a
// scoreboard queue as pixels are driven and popped when valid_out is seen.
module tb_line_buf_3row;

  localparam int W = 4;
  localparam int H = 4;
`ifdef LINE_BUF_EDGE_REPLICATE_EN
  localparam int ExpRows = H;
`else
  localparam int ExpRows = H - 2;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       frame_start;
  logic       valid_in;
  logic [7:0] din;
  logic [7:0] dout1, dout2, dout3;
  logic       valid_out, frame_done;

  typedef struct packed {
    logic [7:0] d1;
    logic [7:0] d2;
    logic [7:0] d3;
    logic       done;
  } exp_t;

  exp_t exp_q[$];
  exp_t last_e;
  int   checks = 0;
  int   errors = 0;

  line_buf_3row #(.WIDTH(8), .PIC_WIDTH(W), .PIC_HEIGHT(H)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .frame_start (frame_start),
    .valid_in    (valid_in),
    .din         (din),
    .dout1       (dout1),
    .dout2       (dout2),
    .dout3       (dout3),
    .valid_out   (valid_out),
    .frame_done  (frame_done)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] pix(input bit hi, input int r, input int c);
    if (hi) return 8'(128 + r * W + c);
    return 8'(r * 16 + c);
  endfunction

  // Expected triple for an accepted pixel at (r, c), if that pixel produces one.
  function automatic void push_exp(input bit hi, input int r, input int c);
    exp_t e;
    bit   v = 1'b0;
    e = '0;
    if (r >= 2) begin
      e.d1 = pix(hi, r - 2, c);
      e.d2 = pix(hi, r - 1, c);
      v    = 1'b1;
    end
`ifdef LINE_BUF_EDGE_REPLICATE_EN
    else begin
      e.d1 = pix(hi, 0, c);
      e.d2 = e.d1;
      v    = 1'b1;
    end
`endif
    e.d3   = pix(hi, r, c);
    e.done = (r == H - 1) && (c == W - 1);
    if (v) exp_q.push_back(e);
  endfunction

  task automatic drive(input bit v, input bit fs, input logic [7:0] d);
    valid_in    = v;
    frame_start = fs;
    din         = d;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 8'h00);
    drive(1'b0, 1'b0, 8'h00);
    checks++;
    if ({dout1, dout2, dout3, valid_out, frame_done} !== 26'd0) begin
      errors++;
      $display("FAIL reset_state got %h %h %h v=%b d=%b want 00 00 00 v=0 d=0",
               dout1, dout2, dout3, valid_out, frame_done);
    end
    last_e = '0;
    rst_n  = 1'b1;
  endtask

  task automatic test_continuous();
    exp_t e;
    int   nvalid = 0;
    for (int idx = 0; idx < W * H + 2; idx++) begin
      if (idx < W * H) begin
        push_exp(1'b0, idx / W, idx % W);
        drive(1'b1, idx == 0, pix(1'b0, idx / W, idx % W));
      end else begin
        drive(1'b0, 1'b0, 8'hEE);
      end
      checks++;
      if (valid_out === 1'b1) begin
        nvalid++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL cont_extra_valid got %h %h %h want no valid", dout1, dout2, dout3);
        end else begin
          e = exp_q.pop_front();
          last_e = e;
          if ({dout1, dout2, dout3, frame_done} !== {e.d1, e.d2, e.d3, e.done}) begin
            errors++;
            $display("FAIL cont_triple got %h %h %h d=%b want %h %h %h d=%b",
                     dout1, dout2, dout3, frame_done, e.d1, e.d2, e.d3, e.done);
          end
        end
      end else if ({dout1, dout2, dout3, frame_done, valid_out} !==
                   {last_e.d1, last_e.d2, last_e.d3, 2'b00}) begin
        errors++;
        $display("FAIL cont_hold got %h %h %h d=%b v=%b want %h %h %h d=0 v=0",
                 dout1, dout2, dout3, frame_done, valid_out, last_e.d1, last_e.d2, last_e.d3);
      end
    end
    checks++;
    if (nvalid != ExpRows * W || exp_q.size() != 0) begin
      errors++;
      $display("FAIL cont_count got %0d valid (%0d pending) want %0d", nvalid, exp_q.size(),
               ExpRows * W);
    end
    exp_q.delete();
  endtask

  task automatic test_toggle();
    exp_t e;
    int   nvalid = 0;
    for (int step = 0; step < 2 * W * H + 2; step++) begin
      if (step % 2 == 0 && step / 2 < W * H) begin
        push_exp(1'b0, (step / 2) / W, (step / 2) % W);
        drive(1'b1, step == 0, pix(1'b0, (step / 2) / W, (step / 2) % W));
      end else begin
        drive(1'b0, 1'b0, 8'($urandom));
      end
      checks++;
      if (valid_out === 1'b1) begin
        nvalid++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL tog_extra_valid got %h %h %h want no valid", dout1, dout2, dout3);
        end else begin
          e = exp_q.pop_front();
          last_e = e;
          if ({dout1, dout2, dout3, frame_done} !== {e.d1, e.d2, e.d3, e.done}) begin
            errors++;
            $display("FAIL tog_triple got %h %h %h d=%b want %h %h %h d=%b",
                     dout1, dout2, dout3, frame_done, e.d1, e.d2, e.d3, e.done);
          end
        end
      end else if ({dout1, dout2, dout3, frame_done, valid_out} !==
                   {last_e.d1, last_e.d2, last_e.d3, 2'b00}) begin
        errors++;
        $display("FAIL tog_hold got %h %h %h d=%b v=%b want %h %h %h d=0 v=0",
                 dout1, dout2, dout3, frame_done, valid_out, last_e.d1, last_e.d2, last_e.d3);
      end
    end
    checks++;
    if (nvalid != ExpRows * W || exp_q.size() != 0) begin
      errors++;
      $display("FAIL tog_count got %0d valid (%0d pending) want %0d", nvalid, exp_q.size(),
               ExpRows * W);
    end
    exp_q.delete();
  endtask

  task automatic test_reset_mid();
    exp_t e;
    // Partial frame up to row 2 col 1, then reset on the row 2 col 2 pixel.
    for (int idx = 0; idx < 2 * W + 2; idx++) begin
      drive(1'b1, idx == 0, pix(1'b0, idx / W, idx % W));
    end
    rst_n = 1'b0;
    drive(1'b1, 1'b0, pix(1'b0, 2, 2));
    rst_n = 1'b1;
    checks++;
    if ({dout1, dout2, dout3, valid_out, frame_done} !== 26'd0) begin
      errors++;
      $display("FAIL midrst_state got %h %h %h v=%b d=%b want 00 00 00 v=0 d=0",
               dout1, dout2, dout3, valid_out, frame_done);
    end
    last_e = '0;
    // Pixels after reset but before frame_start must be ignored.
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 1'b0, 8'h55);
      checks++;
      if ({dout1, dout2, dout3, valid_out, frame_done} !== 26'd0) begin
        errors++;
        $display("FAIL midrst_idle got %h %h %h v=%b d=%b want 00 00 00 v=0 d=0",
                 dout1, dout2, dout3, valid_out, frame_done);
      end
    end
    for (int idx = 0; idx < W * H + 1; idx++) begin
      if (idx < W * H) begin
        push_exp(1'b1, idx / W, idx % W);
        drive(1'b1, idx == 0, pix(1'b1, idx / W, idx % W));
      end else begin
        drive(1'b0, 1'b0, 8'h00);
      end
      checks++;
      if (valid_out === 1'b1) begin
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL midrst_extra_valid got %h %h %h want no valid", dout1, dout2, dout3);
        end else begin
          e = exp_q.pop_front();
          last_e = e;
          if ({dout1, dout2, dout3, frame_done} !== {e.d1, e.d2, e.d3, e.done}) begin
            errors++;
            $display("FAIL midrst_triple got %h %h %h d=%b want %h %h %h d=%b",
                     dout1, dout2, dout3, frame_done, e.d1, e.d2, e.d3, e.done);
          end
        end
      end else if ({dout1, dout2, dout3, frame_done, valid_out} !==
                   {last_e.d1, last_e.d2, last_e.d3, 2'b00}) begin
        errors++;
        $display("FAIL midrst_hold got %h %h %h d=%b v=%b want %h %h %h d=0 v=0",
                 dout1, dout2, dout3, frame_done, valid_out, last_e.d1, last_e.d2, last_e.d3);
      end
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL midrst_pending got %0d want 0", exp_q.size());
    end
    exp_q.delete();
  endtask

  task automatic test_idle_start();
    exp_t e;
    for (int k = 0; k < 4; k++) begin
      drive(k % 2 == 0, 1'b0, 8'($urandom));
      checks++;
      if ({dout1, dout2, dout3, frame_done, valid_out} !==
          {last_e.d1, last_e.d2, last_e.d3, 2'b00}) begin
        errors++;
        $display("FAIL idle_ignore got %h %h %h d=%b v=%b want %h %h %h d=0 v=0",
                 dout1, dout2, dout3, frame_done, valid_out, last_e.d1, last_e.d2, last_e.d3);
      end
    end
    // frame_start together with valid_in: din=0x00 must land at row 0, col 0.
    for (int idx = 0; idx < W * H; idx++) begin
      push_exp(1'b0, idx / W, idx % W);
      drive(1'b1, idx == 0, pix(1'b0, idx / W, idx % W));
      checks++;
      if (valid_out === 1'b1) begin
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL start_extra_valid got %h %h %h want no valid", dout1, dout2, dout3);
        end else begin
          e = exp_q.pop_front();
          last_e = e;
          if ({dout1, dout2, dout3, frame_done} !== {e.d1, e.d2, e.d3, e.done}) begin
            errors++;
            $display("FAIL start_triple got %h %h %h d=%b want %h %h %h d=%b",
                     dout1, dout2, dout3, frame_done, e.d1, e.d2, e.d3, e.done);
          end
        end
      end else if ({dout1, dout2, dout3, frame_done, valid_out} !==
                   {last_e.d1, last_e.d2, last_e.d3, 2'b00}) begin
        errors++;
        $display("FAIL start_hold got %h %h %h d=%b v=%b want %h %h %h d=0 v=0",
                 dout1, dout2, dout3, frame_done, valid_out, last_e.d1, last_e.d2, last_e.d3);
      end
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL start_pending got %0d want 0", exp_q.size());
    end
    exp_q.delete();
    drive(1'b0, 1'b0, 8'h00);
  endtask

  initial begin
    rst_n       = 1'b0;
    frame_start = 1'b0;
    valid_in    = 1'b0;
    din         = 8'h00;
    last_e      = '0;
    test_reset();
    test_continuous();
    test_toggle();
    test_reset_mid();
    test_idle_start();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
